// File: rtl/cmp_arb_pkg.sv
// cmp_arb_pkg: shared types and defaults for the comparator arbiter
package cmp_arb_pkg;
   typedef enum logic [1:0] {IDLE, CMP, HOLD} state_t;
   localparam int WIDTH_DEF  = 6;
   localparam int N_REQ_DEF  = 4;
   localparam int DIFF_CNT_W = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from ptr+1 with wrap
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      idx = '0;
      any = |req;
      // walk the search order backwards so the nearest valid requester wins last
      for (int k = N; k >= 1; k--)
         if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
      gnt = any ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/comparator_arbiter.sv
// comparator_arbiter: round-robin shared 6-bit inequality comparator with tagged,
// backpressured results and a saturating count of differing results
module comparator_arbiter
   import cmp_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*WIDTH-1:0]   req_a,
   input  logic [N_REQ*WIDTH-1:0]   req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic                     rsp_diff,
   output logic                     busy,
   output logic [DIFF_CNT_W-1:0]    diff_count,
   input  logic                     count_clr
);
   localparam int IW = $clog2(N_REQ);
   state_t            state;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     win;
   logic [N_REQ-1:0]  gnt;
   logic              any;
   logic [WIDTH-1:0]  op_a;
   logic [WIDTH-1:0]  op_b;
   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req (req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (win),
      .any (any)
   );
   // rst_n gating keeps req_ready low while reset is held even with requests pending
   assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
   assign busy      = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= IW'(N_REQ - 1);
         op_a       <= '0;
         op_b       <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_diff   <= 1'b0;
         diff_count <= '0;
      end else begin
         case (state)
            IDLE: if (any) begin
               op_a   <= req_a[win*WIDTH +: WIDTH];
               op_b   <= req_b[win*WIDTH +: WIDTH];
               rsp_id <= win;
               ptr    <= win;
               state  <= CMP;
            end
            CMP: begin
               rsp_diff  <= |(op_a ^ op_b);
               rsp_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (count_clr)
            diff_count <= '0;
         else if (state == HOLD && rsp_ready && rsp_diff && diff_count != '1)
            diff_count <= diff_count + DIFF_CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_comparator_arbiter.sv
// tb_comparator_arbiter: directed self-checking bench for comparator_arbiter
module tb_comparator_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [23:0] req_a = '0;
   logic [23:0] req_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_id;
   logic        rsp_diff;
   logic        busy;
   logic [7:0]  diff_count;
   logic        count_clr = 1'b0;
   int          passed = 0;
   int          total = 0;
   comparator_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_diff   (rsp_diff),
      .busy       (busy),
      .diff_count (diff_count),
      .count_clr  (count_clr)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic reset_seq();
      rst_n = 1'b0;
      #1;
      check("rst_valid", rsp_valid, 0);
      check("rst_id", rsp_id, 0);
      check("rst_diff", rsp_diff, 0);
      check("rst_busy", busy, 0);
      check("rst_count", diff_count, 0);
      check("rst_ready", req_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask
   initial begin
      #2;
      reset_seq();
      // single request, equal operands
      req_a[12 +: 6] = 6'b101010;
      req_b[12 +: 6] = 6'b101010;
      req_valid = 4'b0100;
      #1;
      check("single_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      check("single_busy", busy, 1);
      check("single_cmp_valid", rsp_valid, 0);
      check("single_cmp_ready", req_ready, 0);
      tick();
      check("single_valid", rsp_valid, 1);
      check("single_id", rsp_id, 2);
      check("single_diff", rsp_diff, 0);
      rsp_ready = 1'b1;
      tick();
      check("single_done", rsp_valid, 0);
      check("single_count", diff_count, 0);
      check("single_idle", busy, 0);
      // one-bit difference on requester 0; operands change after capture
      req_a[0 +: 6] = 6'b100110;
      req_b[0 +: 6] = 6'b100111;
      req_valid = 4'b0001;
      #1;
      check("onebit_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      req_b[0 +: 6] = 6'b100110;
      tick();
      check("onebit_valid", rsp_valid, 1);
      check("onebit_id", rsp_id, 0);
      check("onebit_diff", rsp_diff, 1);
      tick();
      check("onebit_count", diff_count, 1);
      // fairness from a fresh pointer
      rsp_ready = 1'b0;
      reset_seq();
      req_a = '0;
      req_b = '1;
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("fair_ready", req_ready, 4'b0001 << (i % 4));
         tick();
         check("fair_busy", busy, 1);
         tick();
         check("fair_valid", rsp_valid, 1);
         check("fair_id", rsp_id, i % 4);
         check("fair_diff", rsp_diff, 1);
         tick();
         check("fair_drop", rsp_valid, 0);
      end
      req_valid = '0;
      check("fair_count", diff_count, 5);
      // backpressure: ptr is 0, requester 2 alone
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b1111;
      tick();
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", rsp_valid, 1);
         check("bp_id", rsp_id, 2);
         check("bp_diff", rsp_diff, 1);
         check("bp_ready", req_ready, 0);
         check("bp_busy", busy, 1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      req_valid = '0;
      check("bp_release", rsp_valid, 0);
      check("bp_idle", busy, 0);
      check("bp_count", diff_count, 6);
      // saturation: 256 more differing compares from a count of 6
      req_valid = 4'b1111;
      for (int i = 0; i < 248 * 3; i++) tick();
      check("sat_254", diff_count, 254);
      for (int i = 0; i < 8 * 3; i++) tick();
      check("sat_255", diff_count, 255);
      tick();
      tick();
      check("clr_pending", rsp_diff, 1);
      count_clr = 1'b1;
      tick();
      count_clr = 1'b0;
      req_valid = '0;
      check("clr_priority", diff_count, 0);
      // reset in the middle of a compare
      req_valid = 4'b0010;
      tick();
      check("mid_busy", busy, 1);
      req_valid = 4'b1111;
      rst_n = 1'b0;
      #1;
      check("mid_busy_rst", busy, 0);
      check("mid_valid_rst", rsp_valid, 0);
      check("mid_ready_rst", req_ready, 0);
      check("mid_id_rst", rsp_id, 0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      check("mid_no_stale", rsp_valid, 0);
      check("mid_idle", busy, 0);
      req_valid = 4'b1111;
      #1;
      check("mid_first_grant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      tick();
      check("mid_rsp_valid", rsp_valid, 1);
      check("mid_rsp_id", rsp_id, 0);
      tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
